// File: rtl/fpred_pipe.sv
// Two-stage single-precision predicate/compare unit with valid/ready handshake.
// Stage 1 reduces the operands to sign/zero/magnitude flags; stage 2 forms the result.
module fpred_pipe #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_result,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] F_ISPOS  = 3'd0;
  localparam logic [2:0] F_ISNEG  = 3'd1;
  localparam logic [2:0] F_ISZERO = 3'd2;
  localparam logic [2:0] F_FEQ    = 3'd3;
  localparam logic [2:0] F_FLT    = 3'd4;
  localparam logic [2:0] F_FLE    = 3'd5;

  logic             stall;
  logic             s1_valid_reg;
  logic             sign_a_reg, sign_b_reg;
  logic             zero_a_reg, zero_b_reg;
  logic             mag_lt_reg, mag_eq_reg;
  logic [2:0]       funct_reg;
  logic [TAG_W-1:0] tag_reg;

  logic             feq_next, flt_next;
  logic             result_next, illegal_next;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Stage 1: a held stage keeps its contents, otherwise it takes whatever is offered (bubbles included).
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_reg <= 1'b0;
    end else if (!stall) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        sign_a_reg <= in_a[31];
        sign_b_reg <= in_b[31];
        zero_a_reg <= ~|in_a[30:0];
        zero_b_reg <= ~|in_b[30:0];
        mag_lt_reg <= in_a[30:0] < in_b[30:0];
        mag_eq_reg <= in_a[30:0] == in_b[30:0];
        funct_reg  <= in_funct;
        tag_reg    <= in_tag;
      end
    end
  end

  // +0 and -0 compare equal; otherwise values are ordered as sign-magnitude.
  always_comb begin
    feq_next     = (zero_a_reg & zero_b_reg) | ((sign_a_reg == sign_b_reg) & mag_eq_reg);
    flt_next     = 1'b0;
    result_next  = 1'b0;
    illegal_next = 1'b0;
    if (zero_a_reg & zero_b_reg)
      flt_next = 1'b0;
    else if (sign_a_reg != sign_b_reg)
      flt_next = sign_a_reg;
    else if (!sign_a_reg)
      flt_next = mag_lt_reg;
    else
      flt_next = ~mag_lt_reg & ~mag_eq_reg;

    case (funct_reg)
      F_ISPOS:  result_next = ~zero_a_reg & ~sign_a_reg;
      F_ISNEG:  result_next = ~zero_a_reg & sign_a_reg;
      F_ISZERO: result_next = zero_a_reg;
      F_FEQ:    result_next = feq_next;
      F_FLT:    result_next = flt_next;
      F_FLE:    result_next = flt_next | feq_next;
      default:  illegal_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_result  <= 1'b0;
      out_illegal <= 1'b0;
      out_tag     <= '0;
    end else if (!stall) begin
      out_valid   <= s1_valid_reg;
      out_result  <= result_next;
      out_illegal <= illegal_next;
      out_tag     <= tag_reg;
    end
  end

endmodule

// File: tb/tb_fpred_pipe.sv
// Directed bench for fpred_pipe: hand-computed predicate vectors, back-pressure and mid-flight reset.
module tb_fpred_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic        out_result;
  logic        out_illegal;
  logic [4:0]  out_tag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic        res;
    logic        ill;
  } vec_t;

  vec_t vq[$];

  fpred_pipe #(.TAG_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_illegal(out_illegal), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] tag, input logic res, input logic ill);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.tag = tag; v.res = res; v.ill = ill;
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    in_funct = v.f;
    in_a     = v.a;
    in_b     = v.b;
    in_tag   = v.tag;
  endtask

  // Issues the queued ops back-to-back and expects each one exactly one cycle later.
  task automatic run_queue();
    int n;
    n = vq.size();
    out_ready = 1'b1;
    for (int i = 0; i <= n; i++) begin
      if (i < n) drive(vq[i]);
      else in_valid = 1'b0;
      step();
      if (i == 0) chk("latency_gap", {31'd0, out_valid}, 32'd0);
      else begin
        $display("op tag=%0d funct=%0d a=%h b=%h -> result=%0b illegal=%0b valid=%0b",
                 vq[i-1].tag, vq[i-1].f, vq[i-1].a, vq[i-1].b, out_result, out_illegal, out_valid);
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        chk("out_result", {31'd0, out_result}, {31'd0, vq[i-1].res});
        chk("out_illegal", {31'd0, out_illegal}, {31'd0, vq[i-1].ill});
        chk("out_tag", {27'd0, out_tag}, {27'd0, vq[i-1].tag});
      end
    end
    step();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    vq.delete();
  endtask

  initial begin
    vec_t bp[$];
    int   issued, taken, cyc;
    logic acc, tk;

    reset = 1'b0; in_valid = 1'b0; in_funct = '0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b1;
    step();

    // single op, latency
    add(3'd0, 32'h3F800000, 32'h0, 5'd3, 1'b1, 1'b0);
    run_queue();

    // zero handling
    add(3'd0, 32'h80000000, 32'h0,        5'd10, 1'b0, 1'b0);
    add(3'd2, 32'h80000000, 32'h0,        5'd11, 1'b1, 1'b0);
    add(3'd3, 32'h00000000, 32'h80000000, 5'd12, 1'b1, 1'b0);
    run_queue();

    // ordering, denormals, illegal functs
    add(3'd4, 32'hBF800000, 32'h3F800000, 5'd13, 1'b1, 1'b0);
    add(3'd4, 32'hC0000000, 32'hBF800000, 5'd14, 1'b1, 1'b0);
    add(3'd4, 32'h40000000, 32'h3F800000, 5'd15, 1'b0, 1'b0);
    add(3'd5, 32'hBF800000, 32'hBF800000, 5'd16, 1'b1, 1'b0);
    add(3'd4, 32'h00000000, 32'h80000000, 5'd17, 1'b0, 1'b0);
    add(3'd5, 32'h3F800000, 32'hBF800000, 5'd18, 1'b0, 1'b0);
    add(3'd1, 32'h00000001, 32'h0,        5'd19, 1'b0, 1'b0);
    add(3'd0, 32'h00000001, 32'h0,        5'd20, 1'b1, 1'b0);
    add(3'd4, 32'hBF800000, 32'hC0000000, 5'd21, 1'b0, 1'b0);
    add(3'd3, 32'h3F800000, 32'hBF800000, 5'd22, 1'b0, 1'b0);
    add(3'd7, 32'h3F800000, 32'h0,        5'd9,  1'b0, 1'b1);
    add(3'd6, 32'h00000000, 32'h0,        5'd8,  1'b0, 1'b1);
    run_queue();

    // back-pressure: out_ready low for cycles 2..6
    add(3'd1, 32'hBF800000, 32'h0,        5'd1, 1'b1, 1'b0);
    add(3'd2, 32'h00000000, 32'h0,        5'd2, 1'b1, 1'b0);
    add(3'd3, 32'h40000000, 32'h40000000, 5'd3, 1'b1, 1'b0);
    add(3'd4, 32'h3F800000, 32'h3F800000, 5'd4, 1'b0, 1'b0);
    bp = vq;
    vq.delete();
    issued = 0; taken = 0; cyc = 0;
    while (taken < 4 && cyc < 40) begin
      out_ready = !(cyc >= 2 && cyc < 7);
      if (issued < 4) drive(bp[issued]);
      else in_valid = 1'b0;
      #1;
      acc = in_valid & in_ready;
      tk  = out_valid & out_ready;
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_tag_hold", {27'd0, out_tag}, 32'd1);
      end
      if (tk) begin
        $display("bp take cycle=%0d tag=%0d result=%0b", cyc, out_tag, out_result);
        if (taken < 4) begin
          chk("bp_tag", {27'd0, out_tag}, {27'd0, bp[taken].tag});
          chk("bp_result", {31'd0, out_result}, {31'd0, bp[taken].res});
        end
        taken++;
      end
      if (acc) issued++;
      step();
      cyc++;
    end
    chk("bp_all_taken", taken, 32'd4);
    out_ready = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_no_dup", {31'd0, out_valid}, 32'd0);
      step();
    end

    // reset mid-flight
    add(3'd0, 32'h3F800000, 32'h0, 5'd5, 1'b1, 1'b0);
    add(3'd0, 32'h3F800000, 32'h0, 5'd6, 1'b1, 1'b0);
    drive(vq[0]); step();
    drive(vq[1]); step();
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    chk("mf_stalled_valid", {31'd0, out_valid}, 32'd1);
    chk("mf_stalled_tag", {27'd0, out_tag}, 32'd5);
    reset = 1'b0;
    step();
    $display("mid-flight reset: out_valid=%0b out_tag=%0d in_ready=%0b", out_valid, out_tag, in_ready);
    chk("mf_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mf_rst_tag", {27'd0, out_tag}, 32'd0);
    chk("mf_rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b1; out_ready = 1'b1;
    vq.delete();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mf_no_ghost", {31'd0, out_valid}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
